// File: rtl/regfile_sb.sv
// Scoreboarded register file: DEPTH x DATA_W, two combinational read ports, one writeback, one reservation port.
// Reads are combinational and writes land 1 cycle later; iss_stall_o refuses a reservation on an entry whose producer is still pending.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr_i,
    output logic              iss_stall_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                ready_q;
    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                clearing;
    logic                iss_hit_wr;
    logic                iss_take;
    logic                wr_take;

    // Gating with rst keeps every output at its reset value while reset is held.
    assign run      = rst & ready_q;
    assign clearing = rst & (state_q == INIT);
    assign ready_o  = run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [DATA_W:0] read_port(
        input logic              active,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] entry,
        input logic              entry_busy,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W:0] res;
        res = '0;
        if (active) begin
            if (ZERO_REG && (addr == '0)) begin
                res = '0;
            end else if (BYPASS && wen && (waddr == addr)) begin
                res = {1'b0, wdata};
            end else begin
                res = {entry_busy, entry};
            end
        end
        return res;
    endfunction

    assign {rs1_busy_o, rs1_data_o} = read_port(run, rs1_addr_i, mem_q[rs1_addr_i],
                                                busy_q[rs1_addr_i], wr_en, rd_addr_i, rd_data_i);
    assign {rs2_busy_o, rs2_data_o} = read_port(run, rs2_addr_i, mem_q[rs2_addr_i],
                                                busy_q[rs2_addr_i], wr_en, rd_addr_i, rd_data_i);

    // A writeback retiring the same entry this cycle releases the WAW hazard.
    assign iss_hit_wr  = wr_en & (rd_addr_i == iss_addr_i);
    assign iss_stall_o = run & iss_en & busy_q[iss_addr_i] & ~iss_hit_wr;
    assign iss_take    = run & iss_en & ~iss_stall_o & !(ZERO_REG && (iss_addr_i == '0));
    assign wr_take     = run & wr_en & !(ZERO_REG && (rd_addr_i == '0));

    // Set after clear so a same-entry issue wins over the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (run && wr_en) begin
            busy_d[rd_addr_i] = 1'b0;
        end
        if (iss_take) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_take) begin
            mem_q[rd_addr_i] <= rd_data_i;
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = entry 0 reads 0 and ignores writes/issues.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port ready_o  output  1  high when clear sequence done and block accepts traffic.
REQ-008 SHALL have ports rs1_addr_i, rs2_addr_i  input  ADDR_W  read port indices.
REQ-009 SHALL have ports rs1_data_o, rs2_data_o  output  DATA_W  read data, combinational.
REQ-010 SHALL have ports rs1_busy_o, rs2_busy_o  output  1  source has pending producer.
REQ-011 SHALL have ports wr_en  input  1; rd_addr_i  input  ADDR_W; rd_data_i  input  DATA_W  writeback port.
REQ-012 SHALL have ports iss_en  input  1; iss_addr_i  input  ADDR_W  destination-reservation request.
REQ-013 SHALL have port iss_stall_o  output  1  reservation refused this cycle.

Function
REQ-014 SHALL implement FSM states INIT and RUN; INIT -> RUN after DEPTH clear cycles; RUN held until reset.
REQ-015 SHALL, in INIT, write 0 to entry clr_cnt each cycle, clr_cnt 0..DEPTH-1, then enter RUN the next cycle.
REQ-016 SHALL drive ready_o = 1 only in RUN; first high exactly DEPTH cycles after rst deasserted.
REQ-017 SHALL, in INIT, ignore wr_en and iss_en and drive rsN_data_o = 0, rsN_busy_o = 0, iss_stall_o = 0.
REQ-018 SHALL, in RUN, return rsN_data_o: 0 if ZERO_REG and addr==0; else rd_data_i if BYPASS, wr_en and rd_addr_i==addr; else stored entry.
REQ-019 SHALL commit rd_data_i to entry rd_addr_i at the clock edge when wr_en in RUN (1-cycle write latency), except entry 0 when ZERO_REG.
REQ-020 SHALL keep one busy bit per entry; rsN_busy_o = busy[addr], forced 0 for entry 0 when ZERO_REG, and forced 0 when BYPASS and same-cycle wr_en targets addr.
REQ-021 SHALL clear busy[rd_addr_i] at the edge of any RUN-state write.
REQ-022 SHALL assert iss_stall_o = iss_en & busy[iss_addr_i] & ~(wr_en & rd_addr_i==iss_addr_i) (WAW guard).
REQ-023 SHALL set busy[iss_addr_i] at the edge when iss_en and not iss_stall_o in RUN; ignored for entry 0 when ZERO_REG.
REQ-024 SHALL, when write and accepted issue target the same entry in one cycle, store data and leave busy = 1 (issue wins).
REQ-025 SHALL allow write and issue to different entries in the same cycle with both effects applied.
REQ-026 SHALL keep both read ports fully independent; identical addresses return identical data and busy.

Reset
REQ-027 SHALL, on rst = 0 sampled at an edge, set state INIT, clr_cnt 0, all busy bits 0, ready_o 0.
REQ-028 SHALL restart the full clear sequence when reset occurs mid-INIT or mid-RUN; prior contents not guaranteed until ready_o.
REQ-029 SHALL hold all outputs at reset values while rst = 0 (data 0, busy 0, stall 0, ready 0).

Verification
REQ-030 SHALL cover: rst low 2 cycles, release -> ready_o rises after exactly 32 cycles; all 32 entries then read 0.
REQ-031 SHALL cover: wr_en, rd_addr 5, data 0xDEADBEEF, rs1_addr 5 same cycle -> rs1_data 0xDEADBEEF (BYPASS=1), held next cycle with wr_en 0.
REQ-032 SHALL cover: write 0x1234 to entry 0 -> rs1/rs2 addr 0 read 0; iss_addr 0 -> busy stays 0.
REQ-033 SHALL cover: issue entry 7 -> rs2_busy 1 for addr 7; second issue to 7 -> iss_stall 1; write 7 same cycle as re-issue -> no stall, busy stays 1.
REQ-034 SHALL cover: issue entry 3 then write 3 with 0xA5A5A5A5 -> busy 0 next cycle, data 0xA5A5A5A5.
REQ-035 SHALL cover: rst low in RUN with busy[9] = 1 and entry 9 = 0x55 -> after new clear, ready_o 1, busy 0, entry 9 reads 0.
